// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: handshake and control bundle between the multi-cycle controller and its datapath/memories.
interface multicycle_ctrl_if;
    logic [31:0] inst;
    logic        br_taken;
    logic        imem_rdy;
    logic        dmem_rdy;
    logic        pc_we;
    logic        ir_we;
    logic        imem_re;
    logic        dmem_re;
    logic        dmem_we;
    logic        rf_we;
    logic [5:0]  EXTOp;
    logic [3:0]  alu_op;
    logic        alu_srcb;
    logic [1:0]  npc_sel;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic        busy;
    modport master (
        input  inst, br_taken, imem_rdy, dmem_rdy,
        output pc_we, ir_we, imem_re, dmem_re, dmem_we, rf_we,
        output EXTOp, alu_op, alu_srcb, npc_sel, wb_sel, illegal, busy
    );
    modport slave (
        output inst, br_taken, imem_rdy, dmem_rdy,
        input  pc_we, ir_we, imem_re, dmem_re, dmem_we, rf_we,
        input  EXTOp, alu_op, alu_srcb, npc_sel, wb_sel, illegal, busy
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle FSM controller (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT).
// Defining MULTICYCLE_PERF_EN adds the cyc_cnt/ret_cnt performance counters.
module multicycle_ctrl #(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic              clk,
    input  logic              rstn,
    multicycle_ctrl_if.master bus
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       ret_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  op_q, op_d, op;
    logic [2:0]  f3_q, f3_d, f3;
    logic        f7_q, f7_d, f7;
    logic        illegal_q, illegal_d;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opi, is_op;
    logic        legal, shamt, jump, in_ins, unused_inst;
    // DECODE sees the fields straight from the IR; later states use the latched copy
    assign op          = state_q == DECODE ? bus.inst[6:0] : op_q;
    assign f3          = state_q == DECODE ? bus.inst[14:12] : f3_q;
    assign f7          = state_q == DECODE ? bus.inst[30] : f7_q;
    assign unused_inst = ^{bus.inst[31], bus.inst[29:15], bus.inst[11:7]};
    assign is_lui      = op == 7'b0110111;
    assign is_auipc    = op == 7'b0010111;
    assign is_jal      = op == 7'b1101111;
    assign is_jalr     = op == 7'b1100111;
    assign is_branch   = op == 7'b1100011;
    assign is_load     = op == 7'b0000011;
    assign is_store    = op == 7'b0100011;
    assign is_opi      = op == 7'b0010011;
    assign is_op       = op == 7'b0110011;
    assign legal       = |{is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opi, is_op};
    assign shamt       = is_opi && f3[1:0] == 2'b01;
    assign jump        = is_jal | is_jalr;
    assign in_ins      = state_q inside {DECODE, EXEC, MEM, WB};
    function automatic logic [3:0] alu_of(input logic [2:0] f, input logic alt);
        case (f)
            3'd0:    return alt ? 4'd1 : 4'd0;
            3'd1:    return 4'd2;
            3'd2:    return 4'd3;
            3'd3:    return 4'd4;
            3'd4:    return 4'd5;
            3'd5:    return alt ? 4'd7 : 4'd6;
            3'd6:    return 4'd8;
            default: return 4'd9;
        endcase
    endfunction
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            f3_q      <= '0;
            f7_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            f3_q      <= f3_d;
            f7_q      <= f7_d;
            illegal_q <= illegal_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        f3_d      = f3_q;
        f7_d      = f7_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(RESET_PC_HOLD - 1)) state_d = FETCH;
            end
            FETCH:  if (bus.imem_rdy) state_d = DECODE;
            DECODE: begin
                op_d      = op;
                f3_d      = f3;
                f7_d      = f7;
                illegal_d = illegal_q | !legal;
                state_d   = legal ? EXEC : HALT;
            end
            EXEC:    state_d = is_branch ? FETCH : (is_load | is_store) ? MEM : WB;
            MEM:     if (bus.dmem_rdy) state_d = is_load ? WB : FETCH;
            WB:      state_d = FETCH;
            default: state_d = HALT;
        endcase
    end
    always_comb begin
        bus.pc_we    = 1'b0;
        bus.ir_we    = 1'b0;
        bus.imem_re  = 1'b0;
        bus.dmem_re  = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.rf_we    = 1'b0;
        bus.alu_op   = 4'd0;
        bus.alu_srcb = 1'b0;
        bus.npc_sel  = 2'd0;
        bus.wb_sel   = 2'd0;
        bus.busy     = state_q != IDLE && state_q != HALT;
        bus.illegal  = illegal_q | (state_q == DECODE && !legal);
        bus.EXTOp    = !in_ins ? 6'd0 : shamt ? 6'b100000 : (is_opi | is_load | is_jalr) ? 6'b010000 :
                       is_store ? 6'b001000 : is_branch ? 6'b000100 : (is_lui | is_auipc) ? 6'b000010 :
                       is_jal ? 6'b000001 : 6'd0;
        case (state_q)
            FETCH: begin
                bus.imem_re = 1'b1;
                bus.ir_we   = bus.imem_rdy;
            end
            EXEC: begin
                bus.alu_op   = is_lui ? 4'd10 : is_branch ? (f3[2] ? (f3[1] ? 4'd4 : 4'd3) : 4'd1) :
                               (is_op | is_opi) ? alu_of(f3, f7 & (is_op | shamt)) : 4'd0;
                bus.alu_srcb = !(is_op | is_branch);
                bus.pc_we    = is_branch | jump;
                bus.npc_sel  = is_branch ? {1'b0, bus.br_taken} : is_jalr ? 2'd2 : is_jal ? 2'd1 : 2'd0;
            end
            MEM: begin
                bus.dmem_re = is_load;
                bus.dmem_we = is_store;
                bus.pc_we   = is_store & bus.dmem_rdy;
            end
            WB: begin
                bus.rf_we  = 1'b1;
                bus.wb_sel = is_load ? 2'd1 : jump ? 2'd2 : 2'd0;
                bus.pc_we  = !jump;
            end
            default: ;
        endcase
    end
`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cyc_q, cyc_d, ret_q, ret_d;
    always_comb begin
        cyc_d = cyc_q + {31'd0, bus.busy};
        ret_d = ret_q + {31'd0, bus.pc_we};
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end
    assign cyc_cnt = cyc_q;
    assign ret_cnt = ret_q;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized scoreboard bench for multicycle_ctrl against a per-instruction table model.
module tb_multicycle_ctrl;
    localparam int HOLD = 2;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;
    multicycle_ctrl_if bus();
`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif
    multicycle_ctrl #(.RESET_PC_HOLD(HOLD)) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
`ifdef MULTICYCLE_PERF_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );
    typedef struct {
        logic [6:0] op; logic [2:0] f3; logic [6:0] f7; bit rf3; bit rf7;
        int alu; int ext; int srcb; int cls;
    } ent_t;
    typedef struct {
        int cyc; int ext; int alu; int srcb; int chk_alu; int pcw; int npc;
        int rfw; int wbs; int dre; int dwe; int ill;
    } exp_t;
    // cls: 0 ALU/LUI/AUIPC, 1 load, 2 store, 3 branch, 4 JAL, 5 JALR, 6 illegal
    ent_t tbl [31] = '{
        '{7'h33,3'd0,7'h00,0,0, 0,'b000000,0,0}, '{7'h33,3'd0,7'h20,0,0, 1,'b000000,0,0},
        '{7'h33,3'd1,7'h00,0,0, 2,'b000000,0,0}, '{7'h33,3'd2,7'h00,0,0, 3,'b000000,0,0},
        '{7'h33,3'd3,7'h00,0,0, 4,'b000000,0,0}, '{7'h33,3'd4,7'h00,0,0, 5,'b000000,0,0},
        '{7'h33,3'd5,7'h00,0,0, 6,'b000000,0,0}, '{7'h33,3'd5,7'h20,0,0, 7,'b000000,0,0},
        '{7'h33,3'd6,7'h00,0,0, 8,'b000000,0,0}, '{7'h33,3'd7,7'h00,0,0, 9,'b000000,0,0},
        '{7'h13,3'd0,7'h00,0,1, 0,'b010000,1,0}, '{7'h13,3'd2,7'h00,0,1, 3,'b010000,1,0},
        '{7'h13,3'd3,7'h00,0,1, 4,'b010000,1,0}, '{7'h13,3'd4,7'h00,0,1, 5,'b010000,1,0},
        '{7'h13,3'd6,7'h00,0,1, 8,'b010000,1,0}, '{7'h13,3'd7,7'h00,0,1, 9,'b010000,1,0},
        '{7'h13,3'd1,7'h00,0,0, 2,'b100000,1,0}, '{7'h13,3'd5,7'h00,0,0, 6,'b100000,1,0},
        '{7'h13,3'd5,7'h20,0,0, 7,'b100000,1,0},
        '{7'h37,3'd0,7'h00,1,1,10,'b000010,1,0}, '{7'h17,3'd0,7'h00,1,1, 0,'b000010,1,0},
        '{7'h03,3'd0,7'h00,1,1, 0,'b010000,1,1}, '{7'h23,3'd0,7'h00,1,1, 0,'b001000,1,2},
        '{7'h63,3'd0,7'h00,0,1, 1,'b000100,0,3}, '{7'h63,3'd1,7'h00,0,1, 1,'b000100,0,3},
        '{7'h63,3'd4,7'h00,0,1, 3,'b000100,0,3}, '{7'h63,3'd5,7'h00,0,1, 3,'b000100,0,3},
        '{7'h63,3'd6,7'h00,0,1, 4,'b000100,0,3}, '{7'h63,3'd7,7'h00,0,1, 4,'b000100,0,3},
        '{7'h6F,3'd0,7'h00,1,1, 0,'b000001,1,4}, '{7'h67,3'd0,7'h00,0,1, 0,'b010000,1,5}
    };
    exp_t sbq[$];
    int vectors = 0, miscompares = 0;
    task automatic chk(input string n, input int a, input int x);
        vectors++;
        if (a != x) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, x, $time);
        end
    endtask
    function automatic int outs();
        return int'({bus.pc_we, bus.ir_we, bus.imem_re, bus.dmem_re, bus.dmem_we, bus.rf_we, bus.EXTOp,
                     bus.alu_op, bus.alu_srcb, bus.npc_sel, bus.wb_sel, bus.busy, bus.illegal});
    endfunction
    function automatic logic noise();
        return $urandom_range(0, 3) == 0;
    endfunction
    function automatic int find_ent(input logic [31:0] w);
        for (int i = 0; i < 31; i++)
            if (w[6:0] == tbl[i].op && (tbl[i].rf3 || w[14:12] == tbl[i].f3) && (tbl[i].rf7 || w[31:25] == tbl[i].f7))
                return i;
        return -1;
    endfunction
    function automatic logic [31:0] gen(input int e);
        logic [31:0] w;
        w = $urandom;
        w[6:0] = tbl[e].op;
        if (!tbl[e].rf3) w[14:12] = tbl[e].f3;
        if (!tbl[e].rf7) w[31:25] = tbl[e].f7;
        return w;
    endfunction
    function automatic exp_t model(input int e, input int mw, input bit br);
        exp_t x;
        int c;
        x = '{default: 0};
        c = e < 0 ? 6 : tbl[e].cls;
        if (e >= 0) begin
            x.ext = tbl[e].ext; x.alu = tbl[e].alu; x.srcb = tbl[e].srcb;
        end
        x.pcw = int'(c != 6);
        x.ill = int'(c == 6);
        x.chk_alu = int'(c < 4 || c == 5);
        case (c)
            0:       begin x.cyc = 4; x.rfw = 1; end
            1:       begin x.cyc = 5 + mw; x.rfw = 1; x.wbs = 1; x.dre = mw + 1; end
            2:       begin x.cyc = 4 + mw; x.dwe = mw + 1; end
            3:       begin x.cyc = 3; x.npc = int'(br); end
            4, 5:    begin x.cyc = 4; x.rfw = 1; x.wbs = 2; x.npc = c - 3; end
            default: x.cyc = 2;
        endcase
        return x;
    endfunction
    task automatic issue(input logic [31:0] w, input int mw, input bit br);
        int e, fw, n;
        e = find_ent(w);
        fw = $urandom_range(0, 2);
        n = 0;
        while (!bus.imem_re && n < 50) begin
            bus.imem_rdy = noise(); bus.dmem_rdy = noise();
            @(posedge clk); #1; n++;
        end
        chk("fetch_seen", int'(bus.imem_re), 1);
        if (!bus.imem_re) return;
        bus.imem_rdy = 1'b0;
        repeat (fw) begin
            bus.dmem_rdy = noise();
            @(posedge clk); #1;
        end
        bus.imem_rdy = 1'b1; bus.inst = w; bus.br_taken = br;
        sbq.push_back(model(e, mw, br));
        @(posedge clk); #1;
        bus.imem_rdy = noise();
        if (e >= 0 && tbl[e].cls inside {1, 2}) begin
            n = 0;
            while (!(bus.dmem_re || bus.dmem_we) && n < 10) begin
                bus.dmem_rdy = noise(); bus.imem_rdy = noise();
                @(posedge clk); #1; n++;
            end
            chk("mem_seen", int'(bus.dmem_re || bus.dmem_we), 1);
            if (!(bus.dmem_re || bus.dmem_we)) return;
            bus.dmem_rdy = 1'b0;
            repeat (mw) begin @(posedge clk); #1; end
            bus.dmem_rdy = 1'b1;
            @(posedge clk); #1;
            bus.dmem_rdy = 1'b0;
        end
    endtask
    task automatic release_and_hold();
        int n;
        bus.imem_rdy = 1'b0; bus.dmem_rdy = 1'b0;
        @(negedge clk); rstn = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1; n++;
            if (bus.imem_re) break;
        end
        chk("idle_hold", n, HOLD);
    endtask
    initial begin : monitor
        bit act, pre;
        int cyc, idx, ext, ech, alu, srcb, pcw, npc, rfw, wbs, dre, dwe, ill;
        exp_t x;
        act = 0; pre = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin act = 0; pre = 0; continue; end
            if (act && ((bus.imem_re && !pre) || !bus.busy)) begin
                act = 0;
                chk("sb_pending", int'(sbq.size() > 0), 1);
                if (sbq.size() > 0) begin
                    x = sbq.pop_front();
                    chk("cycles", cyc, x.cyc);
                    chk("extop", ext, x.ext);
                    chk("extop_stable", ech, 0);
                    if (x.chk_alu != 0) begin
                        chk("alu_op", alu, x.alu);
                        chk("alu_srcb", srcb, x.srcb);
                    end
                    chk("pc_we_pulses", pcw, x.pcw);
                    chk("npc_sel", npc, x.npc);
                    chk("rf_we_pulses", rfw, x.rfw);
                    chk("wb_sel", wbs, x.wbs);
                    chk("dmem_re_cycles", dre, x.dre);
                    chk("dmem_we_cycles", dwe, x.dwe);
                    chk("illegal_decode", ill, x.ill);
                end
            end
            if (bus.ir_we) begin
                act = 1; idx = 0; cyc = 0; ext = 0; ech = 0; alu = 0; srcb = 0;
                pcw = 0; npc = 0; rfw = 0; wbs = 0; dre = 0; dwe = 0; ill = 0;
            end
            if (act) begin
                cyc++;
                if (idx == 1) begin ext = int'(bus.EXTOp); ill = int'(bus.illegal); end
                else if (idx > 1 && int'(bus.EXTOp) != ext) ech = 1;
                if (idx == 2) begin alu = int'(bus.alu_op); srcb = int'(bus.alu_srcb); end
                if (bus.pc_we) begin pcw++; npc = int'(bus.npc_sel); end
                if (bus.rf_we) begin rfw++; wbs = int'(bus.wb_sel); end
                dre += int'(bus.dmem_re);
                dwe += int'(bus.dmem_we);
                idx++;
            end
            pre = bus.imem_re;
        end
    end
    initial begin : stim
        int n, e;
        rstn = 1'b0;
        bus.inst = '0; bus.br_taken = 1'b0; bus.imem_rdy = 1'b0; bus.dmem_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset_outs", outs(), 0);
        release_and_hold();
        issue(32'h00500093, 0, 0);
        issue(32'h0000A103, 3, 0);
        issue(32'h0020A223, 1, 0);
        issue(32'h00000463, 0, 1);
        issue(32'h00000463, 0, 0);
        issue(32'h123451B7, 0, 0);
        issue(32'h00309093, 0, 0);
        for (int i = 0; i < 60; i++) begin
            e = $urandom_range(0, 30);
            issue(gen(e), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        issue(32'hFFFFFFFF, 0, 0);
        n = 0;
        while (bus.busy && n < 10) begin @(posedge clk); #1; n++; end
        chk("halted_busy", int'(bus.busy), 0);
        repeat (4) begin
            bus.imem_rdy = noise(); bus.dmem_rdy = noise();
            @(posedge clk); #1;
            chk("halt_outs", outs(), 1);
        end
        @(negedge clk); rstn = 1'b0;
        #1 chk("async_reset_outs", outs(), 0);
        repeat (2) @(posedge clk);
        release_and_hold();
        issue(32'h00500093, 0, 0);
        for (int i = 0; i < 5; i++) begin
            e = $urandom_range(0, 30);
            issue(gen(e), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        bus.imem_rdy = 1'b0;
        n = 0;
        while (sbq.size() > 0 && n < 50) begin @(posedge clk); #1; n++; end
        chk("sb_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main FSM controller for the multi-cycle RV32I build of the core.
- Decodes the instruction register and selects the immediate format (EXTOp) for the immediate extender.
- Sequences the PC, IR, ALU, data memory and register-file enables through FETCH/DECODE/EXEC/MEM/WB.
- Holds in a state while the instruction or data memory handshake is not ready.

Parameters:
- RESET_PC_HOLD, 1: number of cycles the FSM stays in IDLE after reset release before the first FETCH (range 1-15).

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- inst  in  32  instruction register contents, valid from DECODE onward
- br_taken  in  1  branch comparison result from ALU, valid in EXEC
- imem_rdy  in  1  instruction memory read data valid
- dmem_rdy  in  1  data memory access complete
- pc_we  out  1  PC register write enable
- ir_we  out  1  instruction register write enable
- imem_re  out  1  instruction memory read request
- dmem_re  out  1  data memory read request
- dmem_we  out  1  data memory write request
- rf_we  out  1  register file write enable
- EXTOp  out  6  one-hot immediate format: bit5 ITYPE_SHAMT, bit4 ITYPE, bit3 STYPE, bit2 BTYPE, bit1 UTYPE, bit0 JTYPE; 0 = none
- alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
- alu_srcb  out  1  0 rs2, 1 immout
- npc_sel  out  2  0 PC+4, 1 PC+immout, 2 ALU result with bit0 cleared (JALR)
- wb_sel  out  2  0 ALU, 1 memory, 2 PC+4
- illegal  out  1  sticky illegal-opcode flag
- busy  out  1  high in every state except IDLE and HALT

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset: all outputs 0, state IDLE, hold counter 0.
- IDLE: count RESET_PC_HOLD cycles, then go to FETCH.
- FETCH:
  - imem_re=1 while waiting.
  - When imem_rdy: ir_we=1 that cycle, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Latch opcode, funct3 and funct7[5] into internal registers.
  - Drive EXTOp from the latched fields from this state through WB.
  - Unknown opcode: set illegal, go to HALT.
- EXEC:
  - alu_op and alu_srcb driven from the latched fields.
  - Shift-immediate (funct3 001/101 with opcode OP-IMM): EXTOp = ITYPE_SHAMT; funct7[5] selects SRA vs SRL.
  - Routing by class:
    - R/I ALU, LUI: to WB. LUI uses PASSB with UTYPE.
    - AUIPC: alu_srcb=1; the datapath treats srcA as PC; to WB.
    - Load/store: ADD with immediate, then MEM.
    - Branch: SUB/SLT/SLTU per funct3; pc_we=1; npc_sel=1 if br_taken else 0; back to FETCH.
    - JAL: npc_sel=1; JALR: npc_sel=2. Both assert pc_we=1 and go to WB with wb_sel=2.
  - Non-branch, non-jump instructions assert pc_we=1 with npc_sel=0 in their final state.
- MEM:
  - Load: dmem_re=1 until dmem_rdy, then go to WB.
  - Store: dmem_we=1 until dmem_rdy; on dmem_rdy assert pc_we=1 with npc_sel=0 and go to FETCH.
- WB: rf_we=1 for one cycle with wb_sel per class, then FETCH.
- Latency with ready signals tied high:
  - ALU/LUI/AUIPC: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - JAL/JALR: 4 cycles
- rd = x0: rf_we is still pulsed; the register file discards the write.
- Each enable (pc_we, ir_we, rf_we) is a single-cycle pulse per instruction; no double writes during stalls.
- imem_rdy or dmem_rdy asserted outside the matching request state: ignored.
- HALT: all enables 0; only reset exits.
- Reset mid-instruction: immediate return to IDLE; no pending write completes.

Optional Feature:
- Macro: MULTICYCLE_PERF_EN.
- When defined, adds outputs cyc_cnt[31:0] and ret_cnt[31:0].
  - cyc_cnt increments every cycle while busy.
  - ret_cnt increments on each instruction's final-state pc_we.
  - Both wrap at 2^32 and reset to 0.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- addi x1,x0,5 (0x00500093), ready signals high -> states F,D,E,W; EXTOp=010000, alu_op=0, alu_srcb=1, rf_we in cycle 4, wb_sel=0.
- lw x2,0(x1) (0x0000A103), dmem_rdy low for 3 cycles -> dmem_re high 4 cycles, single rf_we pulse with wb_sel=1, EXTOp=010000.
- sw x2,4(x1) (0x0020A223) -> EXTOp=001000, dmem_we asserted, no rf_we, pc_we with npc_sel=0.
- beq x0,x0,8 (0x00000463) with br_taken=1, then br_taken=0 -> EXTOp=000100, npc_sel=1 then 0, 3-cycle latency each.
- lui x3,0x12345 (0x123451B7), then slli x1,x1,3 (0x00309093) -> EXTOp=000010 with PASSB, then 100000 with alu_op=2.
- Illegal word 0xFFFFFFFF -> illegal=1 in DECODE, HALT with busy=0 and all enables 0; rstn pulse low -> outputs 0 and restart at IDLE.
